// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage constants and the fetch FSM state encoding.
package fetch_pc_unit_pkg;
    localparam int CORE_IM_ADDR_BIT = 8;
    localparam int FETCH_ST_BIT     = 2;

    typedef enum logic [FETCH_ST_BIT-1:0] {
        FETCH_ST_RUN    = 2'd0,
        FETCH_ST_HOLD   = 2'd1,
        FETCH_ST_HALTED = 2'd2
    } fetch_st_e;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory read bus: fetch unit is master, synchronous 1-cycle-latency memory is slave.
interface fetch_pc_unit_if #(parameter int AW = fetch_pc_unit_pkg::CORE_IM_ADDR_BIT);
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;

    modport master (output imem_rd_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_rd_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry instruction hold register; shows the held word while valid, else the live memory data.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic        rls,
    input  logic        clear,
    input  logic [31:0] din,
    output logic        hold_valid,
    output logic [31:0] dout
);
    logic [31:0] hold_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_inst  <= '0;
        end else if (clear || rls) begin
            hold_valid <= 1'b0;
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_inst  <= din;
        end
    end

    assign dout = hold_valid ? hold_inst : din;
endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC, IM read issue, stall hold buffer, redirect and halt.
// Define FETCH_PERF_CNT_EN to build the fetch/stall/redirect performance counters.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int IM_ADDR_BIT = CORE_IM_ADDR_BIT,
    parameter int RESET_PC    = 0,
    parameter int PC_STEP     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [IM_ADDR_BIT-1:0] redirect_pc,
    input  logic                   halt,
    fetch_pc_unit_if.master        imem,
    output logic [IM_ADDR_BIT-1:0] pc,
    output logic [IM_ADDR_BIT-1:0] pc_4,
    output logic [31:0]            inst,
    output logic                   inst_valid,
    output logic                   if_id_clr,
    output logic                   halted,
    output logic [31:0]            perf_fetch,
    output logic [31:0]            perf_stall,
    output logic [31:0]            perf_redir
);
    localparam logic [IM_ADDR_BIT-1:0] STEP  = IM_ADDR_BIT'(PC_STEP);
    localparam logic [IM_ADDR_BIT-1:0] PC_RST = IM_ADDR_BIT'(RESET_PC);

    fetch_st_e              state_q, state_d;
    logic [IM_ADDR_BIT-1:0] f_pc, resp_pc;
    logic                   resp_valid, hold_valid;
    logic                   run_ok, redir_acc, advance, capture;
    logic [31:0]            buf_inst;

    // Priority: halt > !en (freeze) > redirect > stall > advance.
    assign run_ok    = (state_q != FETCH_ST_HALTED);
    assign redir_acc = run_ok && !halt && en && redirect;
    assign advance   = rst_n && run_ok && !halt && en && !redirect && !stall;
    assign capture   = run_ok && !halt && !redir_acc && (stall || !en)
                       && resp_valid && (state_q == FETCH_ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH_ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (halt)                          state_d = FETCH_ST_HALTED;
        else if (state_q == FETCH_ST_HALTED) state_d = FETCH_ST_HALTED;
        else if (redir_acc || advance)     state_d = FETCH_ST_RUN;
        else if (capture)                  state_d = FETCH_ST_HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc       <= PC_RST;
            resp_pc    <= '0;
            resp_valid <= 1'b0;
        end else if (halt) begin
            resp_valid <= 1'b0;
        end else if (redir_acc) begin
            f_pc       <= redirect_pc;
            resp_valid <= 1'b0;
        end else if (advance) begin
            f_pc       <= f_pc + STEP;
            resp_pc    <= f_pc;
            resp_valid <= 1'b1;
        end
    end

    fetch_hold_buf u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (capture),
        .rls        (advance),
        .clear      (halt || redir_acc),
        .din        (imem.imem_rdata),
        .hold_valid (hold_valid),
        .dout       (buf_inst)
    );

    assign imem.imem_rd_en = advance;
    assign imem.imem_addr  = f_pc;

    // Outputs read as zero whenever nothing meaningful is presented.
    assign inst_valid = resp_valid;
    assign pc         = resp_valid ? resp_pc : '0;
    assign pc_4       = resp_valid ? resp_pc + STEP : '0;
    assign inst       = resp_valid ? buf_inst : '0;
    assign if_id_clr  = !(rst_n && (halt || redir_acc));
    assign halted     = !run_ok;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= '0;
            perf_stall <= '0;
            perf_redir <= '0;
        end else if (run_ok) begin
            if (advance)      perf_fetch <= perf_fetch + 32'd1;
            if (en && stall)  perf_stall <= perf_stall + 32'd1;
            if (redir_acc)    perf_redir <= perf_redir + 32'd1;
        end
    end
`else
    assign perf_fetch = '0;
    assign perf_stall = '0;
    assign perf_redir = '0;
`endif

    // hold_valid mirrors the HOLD state; kept visible for the mux inside the buffer.
    logic unused_ok;
    assign unused_ok = hold_valid;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, hand sequences, randomized run vs. reference model.
module tb_fetch_pc_unit;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, stall = 1'b0, redirect = 1'b0, halt = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] pc, pc_4;
    logic [31:0]   inst, perf_fetch, perf_stall, perf_redir;
    logic          inst_valid, if_id_clr, halted;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit_if #(.AW(AW)) imem_bus ();

    fetch_pc_unit #(.IM_ADDR_BIT(AW), .RESET_PC(0), .PC_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .imem(imem_bus),
        .pc(pc), .pc_4(pc_4), .inst(inst), .inst_valid(inst_valid),
        .if_id_clr(if_id_clr), .halted(halted),
        .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_redir(perf_redir)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return {8'hA5, a, ~a, a ^ 8'h5A};
    endfunction

    // Synchronous memory; data is scrambled on idle cycles so a stale read cannot pass for a held one.
    always_ff @(posedge clk) begin
        if (imem_bus.imem_rd_en) imem_bus.imem_rdata <= word(imem_bus.imem_addr);
        else                     imem_bus.imem_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic s, input logic r, input logic [AW-1:0] rp, input logic h);
        en = e; stall = s; redirect = r; redirect_pc = rp; halt = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("rst_rd_en", 32'(imem_bus.imem_rd_en), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_pc_4", 32'(pc_4), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_clr", 32'(if_id_clr), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_perf", perf_fetch | perf_stall | perf_redir, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          en, stall, redirect;
        logic [AW-1:0] rpc;
        logic          e_rd;
        logic [AW-1:0] e_addr;
        logic          e_v;
        logic [AW-1:0] e_pc;
        logic          e_clr;
    } vec_t;

    vec_t tbl[17];

    // Reference model: next PC to fetch and what IF/ID is being shown.
    logic [AW-1:0] m_npc, m_ppc;
    logic          m_pv, m_halted;
    int            m_fetch, m_stall, m_redir;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h02, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h03, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h04, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h05, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h06, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 8'h07, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'h40, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 8'h00, 1'b1};

        // Directed table: start-up latency, 3-cycle stall, redirect under stall, freeze, redirect.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].en, tbl[i].stall, tbl[i].redirect, tbl[i].rpc, 1'b0);
            #1;
            chk($sformatf("t%0d_rd_en", i), 32'(imem_bus.imem_rd_en), 32'(tbl[i].e_rd));
            if (tbl[i].e_rd) chk($sformatf("t%0d_addr", i), 32'(imem_bus.imem_addr), 32'(tbl[i].e_addr));
            chk($sformatf("t%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_v));
            chk($sformatf("t%0d_clr", i), 32'(if_id_clr), 32'(tbl[i].e_clr));
            if (tbl[i].e_v) begin
                chk($sformatf("t%0d_pc", i), 32'(pc), 32'(tbl[i].e_pc));
                chk($sformatf("t%0d_inst", i), inst, word(tbl[i].e_pc));
            end
            @(negedge clk);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("tbl_perf_fetch", perf_fetch, 32'd11);
        chk("tbl_perf_stall", perf_stall, 32'd4);
        chk("tbl_perf_redir", perf_redir, 32'd2);
`else
        chk("tbl_perf_off", perf_fetch | perf_stall | perf_redir, 32'd0);
`endif

        // PC wrap at the top of the address space.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0); #1;
        chk("wrap_redir_clr", 32'(if_id_clr), 32'd0);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); #1;
        chk("wrap_addr_ff", 32'(imem_bus.imem_addr), 32'hFF);
        @(negedge clk); #1;
        chk("wrap_addr_0", 32'(imem_bus.imem_addr), 32'h00);
        chk("wrap_pc", 32'(pc), 32'hFF);
        chk("wrap_pc_4", 32'(pc_4), 32'h00);
        chk("wrap_inst", inst, word(8'hFF));

        // Halt beats a concurrent redirect and sticks until reset.
        @(negedge clk); drive(1'b1, 1'b0, 1'b1, 8'h20, 1'b1); #1;
        chk("halt_clr", 32'(if_id_clr), 32'd0);
        chk("halt_rd_en", 32'(imem_bus.imem_rd_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1'b1, 1'b0, k[0], 8'h20, 1'b0); #1;
            chk("halted_flag", 32'(halted), 32'd1);
            chk("halted_rd_en", 32'(imem_bus.imem_rd_en), 32'd0);
            chk("halted_valid", 32'(inst_valid), 32'd0);
        end
        do_reset(); #1;
        chk("post_halt_rd_en", 32'(imem_bus.imem_rd_en), 32'd1);
        chk("post_halt_addr", 32'(imem_bus.imem_addr), 32'd0);
        chk("post_halt_flag", 32'(halted), 32'd0);

        // Randomized segments against the reference model.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            m_npc = '0; m_ppc = '0; m_pv = 1'b0; m_halted = 1'b0;
            m_fetch = 0; m_stall = 0; m_redir = 0;
            for (int c = 0; c < 300; c++) begin
                logic e_rd, e_clr;
                drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 249) == 0);
                e_rd  = !m_halted && !halt && en && !redirect && !stall;
                e_clr = !(halt || (!m_halted && en && redirect));
                #1;
                chk("r_rd_en", 32'(imem_bus.imem_rd_en), 32'(e_rd));
                if (e_rd) chk("r_addr", 32'(imem_bus.imem_addr), 32'(m_npc));
                chk("r_clr", 32'(if_id_clr), 32'(e_clr));
                chk("r_halted", 32'(halted), 32'(m_halted));
                chk("r_valid", 32'(inst_valid), 32'(m_pv));
                if (m_pv) begin
                    chk("r_pc", 32'(pc), 32'(m_ppc));
                    chk("r_pc_4", 32'(pc_4), 32'(AW'(m_ppc + 8'd1)));
                    chk("r_inst", inst, word(m_ppc));
                end
                if (!m_halted && en && stall) m_stall++;
                if (halt) begin
                    m_halted = 1'b1; m_pv = 1'b0;
                end else if (!m_halted && en) begin
                    if (redirect) begin
                        m_npc = redirect_pc; m_pv = 1'b0; m_redir++;
                    end else if (!stall) begin
                        m_ppc = m_npc; m_pv = 1'b1; m_npc = AW'(m_npc + 8'd1); m_fetch++;
                    end
                end
                @(negedge clk);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("r_perf_fetch", perf_fetch, 32'(m_fetch));
            chk("r_perf_stall", perf_stall, 32'(m_stall));
            chk("r_perf_redir", perf_redir, 32'(m_redir));
`else
            chk("r_perf_off", perf_fetch | perf_stall | perf_redir, 32'd0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
